bitty_fetch_seq: RTL and testbench

Parametrised fetch/issue sequencer for the bitty core: drives the instruction-memory address from its own program counter, waits a configurable memory read latency, hands each instruction to the core with a one-cycle run pulse, and advances the PC on the core's done (sequential or branch target). It replaces the fixed 4-state run counter with continuous, single-step and halt modes, a done-watchdog, and a retired-instruction counter. It sits between the instruction memory, branch logic and the `bitty` core in the top level.

---
 rtl/bitty_fetch_seq.sv | 143 ++++++++++++++
 tb/tb_bitty_fetch_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_fetch_seq.sv
// Fetch/issue sequencer for the bitty core: fetches from its own PC, issues each
// instruction with a one-cycle run pulse and retires it on core_done.
module bitty_fetch_seq #(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 16,
    parameter int FETCH_LAT = 2,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] core_instr,
    output logic               core_run,
    input  logic               core_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_EXEC      = 3'd3;
    localparam logic [2:0] ST_STEP_WAIT = 3'd4;
    localparam logic [2:0] ST_HALTED    = 3'd5;

    // Fetch counter counts down to zero; watchdog expires on its TIMEOUT-th EXEC edge.
    localparam logic [3:0]  LAT_LOAD = 4'(FETCH_LAT - 1);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

    logic [2:0]  state_r;
    logic [3:0]  lat_r;
    logic [15:0] wd_r;
    logic        halt_r;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur,
                                                  input logic              taken,
                                                  input logic [ADDR_W-1:0] target);
        return taken ? target : cur + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    assign mem_addr = pc;

    // Status flags decoded straight from the state register.
    always_comb begin
        busy   = (state_r == ST_FETCH) || (state_r == ST_ISSUE) || (state_r == ST_EXEC);
        halted = (state_r == ST_HALTED);
    end

    // Sequencer state, PC, issue register, watchdog and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lat_r      <= 4'd0;
            wd_r       <= 16'd0;
            halt_r     <= 1'b0;
            pc         <= '0;
            core_instr <= '0;
            core_run   <= 1'b0;
            fault      <= 1'b0;
            retired    <= '0;
        end else begin
            core_run <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                        lat_r   <= LAT_LOAD;
                    end
                end
                ST_FETCH: begin
                    if (halt_req) halt_r <= 1'b1;
                    if (lat_r == 4'd0) begin
                        core_instr <= mem_rdata;
                        core_run   <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        lat_r <= lat_r - 4'd1;
                    end
                end
                ST_ISSUE: begin
                    if (halt_req) halt_r <= 1'b1;
                    wd_r    <= 16'd0;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    // A done on the expiry edge still retires cleanly.
                    if (core_done) begin
                        pc <= next_pc(pc, branch_taken, branch_target);
                        if (retired != {CNT_W{1'b1}}) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (halt_r || halt_req) begin
                            state_r <= ST_HALTED;
                            halt_r  <= 1'b0;
                        end else if (step_mode) begin
                            state_r <= ST_STEP_WAIT;
                        end else begin
                            state_r <= ST_FETCH;
                            lat_r   <= LAT_LOAD;
                        end
                    end else if (wd_r == WD_LAST) begin
                        fault   <= 1'b1;
                        state_r <= ST_HALTED;
                        halt_r  <= 1'b0;
                    end else begin
                        wd_r <= wd_r + 16'd1;
                        if (halt_req) halt_r <= 1'b1;
                    end
                end
                ST_STEP_WAIT: begin
                    if (halt_req || halt_r) begin
                        state_r <= ST_HALTED;
                        halt_r  <= 1'b0;
                    end else if (step) begin
                        state_r <= ST_FETCH;
                        lat_r   <= LAT_LOAD;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                        lat_r   <= LAT_LOAD;
                        fault   <= 1'b0;
                        halt_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_fetch_seq.sv
// Directed bench for bitty_fetch_seq: timestamp-based reference model checked every
// cycle, plus literal expectations for the headline timing and counter values.
module tb_bitty_fetch_seq;

    localparam int LAT = 2;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        reset, start, step_mode, step, halt_req;
    logic [7:0]  mem_addr, pc, branch_target;
    logic [15:0] mem_rdata, core_instr, retired;
    logic        core_run, core_done, branch_taken, busy, halted, fault;

    bitty_fetch_seq #(.ADDR_W(8), .INSTR_W(16), .FETCH_LAT(LAT), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .halt_req(halt_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .core_instr(core_instr), .core_run(core_run), .core_done(core_done),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
        .busy(busy), .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [256];
    logic        bt_valid [256];
    logic [7:0]  bt_target [256];
    assign mem_rdata = imem[mem_addr];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: each issue is scheduled as an absolute cycle number.
    localparam int MD_IDLE = 0, MD_BUSY = 1, MD_WAIT = 2, MD_HALT = 3;
    int          cyc, mode, run_at;
    logic [7:0]  m_pc;
    logic [15:0] m_ret, m_instr;
    logic        m_fault, m_pend, m_run;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; mode = MD_IDLE; run_at = 0; m_pc = 8'd0; m_ret = 16'd0;
            m_instr = 16'd0; m_fault = 1'b0; m_pend = 1'b0; m_run = 1'b0;
        end else begin
            cyc++;
            m_run = 1'b0;
            case (mode)
                MD_IDLE: if (start) begin mode = MD_BUSY; run_at = cyc + LAT; end
                MD_BUSY: begin
                    if (halt_req) m_pend = 1'b1;
                    if (cyc == run_at) begin
                        m_instr = imem[m_pc];
                        m_run   = 1'b1;
                    end else if (cyc > run_at + 1) begin
                        if (core_done) begin
                            m_pc = branch_taken ? branch_target : m_pc + 8'd1;
                            if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
                            if (m_pend) begin mode = MD_HALT; m_pend = 1'b0; end
                            else if (step_mode) mode = MD_WAIT;
                            else run_at = cyc + LAT;
                        end else if (cyc - run_at - 1 == TO) begin
                            m_fault = 1'b1; mode = MD_HALT; m_pend = 1'b0;
                        end
                    end
                end
                MD_WAIT: begin
                    if (halt_req || m_pend) begin mode = MD_HALT; m_pend = 1'b0; end
                    else if (step) begin mode = MD_BUSY; run_at = cyc + LAT; end
                end
                MD_HALT: if (start) begin
                    mode = MD_BUSY; run_at = cyc + LAT; m_fault = 1'b0; m_pend = 1'b0;
                end
                default: mode = MD_IDLE;
            endcase
        end
    end

    logic cmp_en = 1'b0, rec_en = 1'b0;
    int   t0;
    int   run_q[$];
    logic [7:0] run_pc_q[$];

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("pc", pc, m_pc);
            chk("mem_addr", mem_addr, m_pc);
            chk("core_run", core_run, m_run);
            chk("core_instr", core_instr, m_instr);
            chk("busy", busy, mode == MD_BUSY);
            chk("halted", halted, mode == MD_HALT);
            chk("fault", fault, m_fault);
            chk("retired", retired, m_ret);
            if (rec_en && core_run) begin
                run_q.push_back(cyc - t0);
                run_pc_q.push_back(pc);
            end
        end
    end

    // Core stand-in: answers each run pulse resp_delay cycles later.
    logic       resp_en = 1'b0;
    int         resp_delay = 3;
    int         d;
    logic [7:0] p;
    initial begin
        core_done = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
        forever begin
            @(negedge clk);
            if (core_run && resp_en) begin
                d = resp_delay; p = pc;
                repeat (d) @(posedge clk);
                #1;
                core_done = 1'b1; branch_taken = bt_valid[p]; branch_target = bt_target[p];
                @(posedge clk);
                #1;
                core_done = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
            end
        end
    end

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: start = 1'b1;
            1: step = 1'b1;
            default: halt_req = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; step = 1'b0; halt_req = 1'b0;
    endtask

    // Negedges from the pulse's sampling cycle up to the run pulse.
    task automatic measure_run(output int lat);
        lat = 1;
        while (!core_run && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int n, lat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i]      = 16'hA000 ^ (16'(i) * 16'h0101);
            bt_valid[i]  = 1'b0;
            bt_target[i] = 8'd0;
        end
        bt_valid[5]     = 1'b1; bt_target[5]     = 8'h20;
        bt_valid[8'h21] = 1'b1; bt_target[8'h21] = 8'hFE;
        reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 0); chk("rst_run", core_run, 0); chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0); chk("rst_fault", fault, 0);
        chk("rst_retired", retired, 0); chk("rst_instr", core_instr, 0);
        reset = 1'b0; cmp_en = 1'b1;

        // Continuous run with branches and PC wrap
        resp_en = 1'b1; resp_delay = 3; rec_en = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        @(negedge clk); start = 1'b0;
        for (n = 0; n < 40 && run_q.size() < 3; n++) @(negedge clk);
        chk("three_runs_seen", run_q.size() >= 3, 1);
        if (run_q.size() >= 3) begin
            chk("run0_cycle", run_q[0], 2); chk("run1_cycle", run_q[1], 8);
            chk("run2_cycle", run_q[2], 14);
            chk("run0_pc", run_pc_q[0], 0); chk("run1_pc", run_pc_q[1], 1);
            chk("run2_pc", run_pc_q[2], 2);
        end
        rec_en = 1'b0;
        for (n = 0; n < 20 && retired != 16'd3; n++) @(negedge clk);
        chk("retired_3", retired, 3); chk("pc_after_3", pc, 3);
        for (n = 0; n < 100 && pc != 8'h20; n++) @(negedge clk);
        chk("branch_mem_addr", mem_addr, 8'h20);
        for (n = 0; n < 100 && retired != 16'd10; n++) @(negedge clk);
        chk("wrap_retired", retired, 10); chk("wrap_pc", pc, 8'h00);

        // Halt request during EXEC
        for (n = 0; n < 20 && !core_run; n++) @(negedge clk);
        pulse(2);
        for (n = 0; n < 20 && !halted; n++) @(negedge clk);
        chk("halt_halted", halted, 1); chk("halt_pc", pc, 1); chk("halt_retired", retired, 11);
        n = 0;
        repeat (10) begin @(negedge clk); if (core_run) n++; end
        chk("halt_no_run", n, 0);
        pulse(0);
        measure_run(lat);
        chk("resume_latency", lat, 3); chk("resume_pc", pc, 1);

        // Single step
        step_mode = 1'b1;
        for (n = 0; n < 30 && (busy || halted); n++) @(negedge clk);
        chk("step_wait_idle", busy | halted, 0);
        n = 0;
        repeat (20) begin @(negedge clk); if (core_run) n++; end
        chk("step_no_run", n, 0);
        pulse(1);
        measure_run(lat);
        chk("step_latency", lat, 3); chk("step_pc", pc, 2);
        @(negedge clk);
        for (n = 0; n < 30 && (busy || halted); n++) @(negedge clk);
        pulse(2);
        chk("step_halt", halted, 1); chk("step_halt_pc", pc, 3);
        chk("step_halt_retired", retired, 13);
        step_mode = 1'b0;

        // Watchdog expiry
        resp_en = 1'b0;
        pulse(0);
        measure_run(lat);
        n = 0;
        while (!fault && n < 40) begin @(negedge clk); n++; end
        chk("wd_cycles", n, 11); chk("wd_halted", halted, 1);
        chk("wd_pc", pc, 3); chk("wd_retired", retired, 13);

        // Done on the expiry edge beats the watchdog
        resp_en = 1'b1; resp_delay = 10;
        pulse(0);
        measure_run(lat);
        pulse(2);
        for (n = 0; n < 30 && !halted; n++) @(negedge clk);
        chk("coinc_halted", halted, 1); chk("coinc_fault", fault, 0);
        chk("coinc_pc", pc, 4); chk("coinc_retired", retired, 14);

        // Reset in EXEC; the core's late done must be ignored
        resp_delay = 5;
        pulse(0);
        measure_run(lat);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 0); chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_run", core_run, 0); chk("mid_rst_instr", core_instr, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_halted", halted, 0);
        chk("mid_rst_fault", fault, 0); chk("mid_rst_retired", retired, 0);
        @(negedge clk); #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_retired", retired, 0); chk("post_rst_pc", pc, 0);
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
